// File: rtl/sr_pulse_encoder.sv
// Debounces level input d and encodes each accepted edge as a PULSE_W-cycle s (rise) or r (fall) pulse.
// Outputs are registered; the first pulse cycle follows the DEB_CYCLES-th matching sample. No backpressure.
module sr_pulse_encoder #(
   parameter int DEB_CYCLES = 4,
   parameter int PULSE_W    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       d,
   output logic       s,
   output logic       r,
   output logic       level,
   output logic       busy,
   output logic [7:0] evt_cnt
);

   typedef enum logic [2:0] {
      ST_LOW     = 3'd0,
      ST_FILT_UP = 3'd1,
      ST_SET_P   = 3'd2,
      ST_HIGH    = 3'd3,
      ST_FILT_DN = 3'd4,
      ST_RST_P   = 3'd5
   } state_t;

   localparam logic [7:0] DEB_V = 8'(DEB_CYCLES);
   localparam logic [7:0] PW_V  = 8'(PULSE_W);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] pw_q, pw_d;
   logic       s_q, s_d;
   logic       r_q, r_d;
   logic       level_q, level_d;
   logic       busy_q, busy_d;
   logic [7:0] evt_q, evt_d;
   logic       pulse_start;

   // State register: every flop clears asynchronously so a pulse in flight is cut immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOW;
         cnt_q   <= 8'd0;
         pw_q    <= 8'd0;
         s_q     <= 1'b0;
         r_q     <= 1'b0;
         level_q <= 1'b0;
         busy_q  <= 1'b0;
         evt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pw_q    <= pw_d;
         s_q     <= s_d;
         r_q     <= r_d;
         level_q <= level_d;
         busy_q  <= busy_d;
         evt_q   <= evt_d;
      end
   end

   // Next-state logic. cnt counts consecutive matching samples; pw counts pulse cycles already emitted.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pw_d    = pw_q;
      case (state_q)
         ST_LOW: begin
            if (en && d) begin
               if (DEB_V == 8'd1) begin
                  state_d = ST_SET_P;
                  cnt_d   = 8'd0;
                  pw_d    = 8'd1;
               end else begin
                  state_d = ST_FILT_UP;
                  cnt_d   = 8'd1;
               end
            end
         end
         ST_FILT_UP: begin
            if (!en || !d) begin
               state_d = ST_LOW;
               cnt_d   = 8'd0;
            end else if (cnt_q + 8'd1 == DEB_V) begin
               state_d = ST_SET_P;
               cnt_d   = 8'd0;
               pw_d    = 8'd1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_SET_P: begin
            if (pw_q == PW_V) begin
               state_d = ST_HIGH;
               pw_d    = 8'd0;
            end else begin
               pw_d = pw_q + 8'd1;
            end
         end
         ST_HIGH: begin
            if (en && !d) begin
               if (DEB_V == 8'd1) begin
                  state_d = ST_RST_P;
                  cnt_d   = 8'd0;
                  pw_d    = 8'd1;
               end else begin
                  state_d = ST_FILT_DN;
                  cnt_d   = 8'd1;
               end
            end
         end
         ST_FILT_DN: begin
            if (!en || d) begin
               state_d = ST_HIGH;
               cnt_d   = 8'd0;
            end else if (cnt_q + 8'd1 == DEB_V) begin
               state_d = ST_RST_P;
               cnt_d   = 8'd0;
               pw_d    = 8'd1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RST_P: begin
            if (pw_q == PW_V) begin
               state_d = ST_LOW;
               pw_d    = 8'd0;
            end else begin
               pw_d = pw_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = 8'd0;
            pw_d    = 8'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the flops present them on the same edge the state changes.
   always_comb begin
      s_d         = (state_d == ST_SET_P);
      r_d         = (state_d == ST_RST_P);
      busy_d      = (state_d != ST_LOW) && (state_d != ST_HIGH);
      level_d     = (state_d == ST_SET_P) || (state_d == ST_HIGH) || (state_d == ST_FILT_DN);
      pulse_start = ((state_d == ST_SET_P) && (state_q != ST_SET_P)) ||
                    ((state_d == ST_RST_P) && (state_q != ST_RST_P));
      evt_d       = pulse_start ? evt_q + 8'd1 : evt_q;
   end

   assign s       = s_q;
   assign r       = r_q;
   assign level   = level_q;
   assign busy    = busy_q;
   assign evt_cnt = evt_q;

endmodule

// File: tb/tb_sr_pulse_encoder.sv
// Directed bench: default-parameter encoder plus a DEB_CYCLES=1/PULSE_W=1 instance sharing clock and reset.
module tb_sr_pulse_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, d, en2, d2;
   logic       s, r, level, busy;
   logic       s2, r2, level2, busy2;
   logic [7:0] evt_cnt, evt_cnt2;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   sr_pulse_encoder #(.DEB_CYCLES(4), .PULSE_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .d(d),
      .s(s), .r(r), .level(level), .busy(busy), .evt_cnt(evt_cnt)
   );

   sr_pulse_encoder #(.DEB_CYCLES(1), .PULSE_W(1)) dut_fast (
      .clk(clk), .rst_n(rst_n), .en(en2), .d(d2),
      .s(s2), .r(r2), .level(level2), .busy(busy2), .evt_cnt(evt_cnt2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves reset released 1 time unit after an edge, so the next edge is "edge 1".
   task automatic do_reset();
      rst_n = 1'b0;
      d = 1'b0; en = 1'b1; d2 = 1'b0; en2 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      d = 1'b1; en = 1'b1; d2 = 1'b1; en2 = 1'b1;
      #1;
      checks++;
      if ({s, r, level, busy, evt_cnt} !== 12'd0) begin
         errors++;
         $display("FAIL reset_imm got s=%b r=%b lvl=%b busy=%b evt=%0d want all 0", s, r, level, busy, evt_cnt);
      end
      repeat (3) tick();
      checks++;
      if ({s, r, level, busy, evt_cnt, s2, r2, level2, busy2, evt_cnt2} !== 24'd0) begin
         errors++;
         $display("FAIL reset_hold got s=%b r=%b busy=%b busy2=%b s2=%b want all 0", s, r, busy, busy2, s2);
      end
   endtask

   task automatic test_set_pulse();
      do_reset();
      d = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         checks++;
         if (s !== (e == 4 || e == 5)) begin
            errors++; $display("FAIL set_s edge %0d got %b want %b", e, s, (e == 4 || e == 5));
         end
         checks++;
         if (level !== (e >= 4)) begin
            errors++; $display("FAIL set_level edge %0d got %b want %b", e, level, (e >= 4));
         end
         checks++;
         if (busy !== (e <= 5)) begin
            errors++; $display("FAIL set_busy edge %0d got %b want %b", e, busy, (e <= 5));
         end
         checks++;
         if (evt_cnt !== ((e >= 4) ? 8'd1 : 8'd0)) begin
            errors++; $display("FAIL set_evt edge %0d got %0d want %0d", e, evt_cnt, (e >= 4) ? 1 : 0);
         end
         checks++;
         if (r !== 1'b0) begin
            errors++; $display("FAIL set_r edge %0d got %b want 0", e, r);
         end
      end
   endtask

   // Runs from HIGH left by test_set_pulse: a 3-sample low glitch must be rejected.
   task automatic test_glitch_dn();
      d = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         tick();
         checks++;
         if (busy !== 1'b1 || r !== 1'b0 || level !== 1'b1) begin
            errors++; $display("FAIL glitch_filt edge %0d got busy=%b r=%b lvl=%b want 1 0 1", e, busy, r, level);
         end
      end
      d = 1'b1;
      for (int e = 4; e <= 9; e++) begin
         tick();
         checks++;
         if (busy !== 1'b0 || r !== 1'b0 || s !== 1'b0 || level !== 1'b1 || evt_cnt !== 8'd1) begin
            errors++;
            $display("FAIL glitch_ret edge %0d got busy=%b r=%b s=%b lvl=%b evt=%0d want 0 0 0 1 1",
                     e, busy, r, s, level, evt_cnt);
         end
      end
   endtask

   task automatic test_toggle_in_pulse();
      do_reset();
      d = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         tick();
         if (e == 4) d = 1'b0;
         checks++;
         if (s !== (e == 4 || e == 5)) begin
            errors++; $display("FAIL tog_s edge %0d got %b want %b", e, s, (e == 4 || e == 5));
         end
         checks++;
         if (r !== (e == 10 || e == 11)) begin
            errors++; $display("FAIL tog_r edge %0d got %b want %b", e, r, (e == 10 || e == 11));
         end
         checks++;
         if (level !== (e >= 4 && e <= 9)) begin
            errors++; $display("FAIL tog_level edge %0d got %b want %b", e, level, (e >= 4 && e <= 9));
         end
      end
      checks++;
      if (evt_cnt !== 8'd2 || busy !== 1'b0) begin
         errors++; $display("FAIL tog_end got evt=%0d busy=%b want 2 0", evt_cnt, busy);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      d = 1'b1;
      repeat (4) tick();
      d = 1'b0;
      repeat (6) tick();
      checks++;
      if (r !== 1'b1 || evt_cnt !== 8'd2) begin
         errors++; $display("FAIL ares_pre got r=%b evt=%0d want 1 2", r, evt_cnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (r !== 1'b0 || level !== 1'b0 || evt_cnt !== 8'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL ares_imm got r=%b lvl=%b evt=%0d busy=%b want 0 0 0 0", r, level, evt_cnt, busy);
      end
      tick();
      rst_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         checks++;
         if (r !== 1'b0 || s !== 1'b0 || busy !== 1'b0 || evt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL ares_after edge %0d got r=%b s=%b busy=%b evt=%0d want 0", e, r, s, busy, evt_cnt);
         end
      end
      do_reset();
      d = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b1 || level !== 1'b0) begin
         errors++; $display("FAIL ares_first got busy=%b lvl=%b want 1 0", busy, level);
      end
   endtask

   task automatic test_wrap_and_disable();
      do_reset();
      for (int p = 0; p < 128; p++) begin
         d = 1'b1;
         repeat (6) tick();
         d = 1'b0;
         repeat (6) tick();
         if (p == 0) begin
            checks++;
            if (evt_cnt !== 8'd2) begin
               errors++; $display("FAIL wrap_first got %0d want 2", evt_cnt);
            end
         end
         if (p == 126) begin
            checks++;
            if (evt_cnt !== 8'd254) begin
               errors++; $display("FAIL wrap_254 got %0d want 254", evt_cnt);
            end
         end
      end
      checks++;
      if (evt_cnt !== 8'd0 || level !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL wrap_end got evt=%0d lvl=%b busy=%b want 0 0 0", evt_cnt, level, busy);
      end
      en = 1'b0;
      for (int e = 0; e < 20; e++) begin
         d = e[1];
         tick();
         checks++;
         if (busy !== 1'b0 || s !== 1'b0 || r !== 1'b0 || evt_cnt !== 8'd0) begin
            errors++;
            $display("FAIL dis edge %0d got busy=%b s=%b r=%b evt=%0d want 0", e, busy, s, r, evt_cnt);
         end
      end
      en = 1'b1;
   endtask

   task automatic test_fast();
      do_reset();
      for (int e = 1; e <= 12; e++) begin
         d2 = (((e - 1) % 6) < 3);
         tick();
         checks++;
         if (s2 !== (((e - 1) % 6) == 0) || r2 !== (((e - 1) % 6) == 3)) begin
            errors++;
            $display("FAIL fast_sr edge %0d got s=%b r=%b want %b %b", e, s2, r2,
                     (((e - 1) % 6) == 0), (((e - 1) % 6) == 3));
         end
         checks++;
         if (level2 !== (((e - 1) % 6) < 3)) begin
            errors++; $display("FAIL fast_level edge %0d got %b want %b", e, level2, (((e - 1) % 6) < 3));
         end
         checks++;
         if (evt_cnt2 !== 8'((e + 2) / 3)) begin
            errors++; $display("FAIL fast_evt edge %0d got %0d want %0d", e, evt_cnt2, (e + 2) / 3);
         end
      end
   endtask

   initial begin
      test_reset();
      test_set_pulse();
      test_glitch_dn();
      test_toggle_in_pulse();
      test_async_reset();
      test_wrap_and_disable();
      test_fast();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule

// File: doc/sr_pulse_encoder.md
SR_PULSE_ENCODER -- requirements
Module: sr_pulse_encoder

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive samples of a new level of d required before it is accepted; legal range 1..255.
REQ-002 Parameter PULSE_W, default 2: width in clock cycles of each emitted s or r pulse; legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port en, input, 1: enable for detecting new transitions of d.
REQ-006 Port d, input, 1: level input to be encoded into set/reset pulses.
REQ-007 Port s, output, 1: set pulse, registered, intended to drive the s input of a downstream SR flip-flop.
REQ-008 Port r, output, 1: reset pulse, registered, intended to drive the r input of a downstream SR flip-flop.
REQ-009 Port level, output, 1: registered copy of the level the downstream SR flip-flop holds after the pulses issued so far.
REQ-010 Port busy, output, 1: high while filtering or pulsing; low in a stable state.
REQ-011 Port evt_cnt, output, 8: count of pulses issued, wrapping modulo 256.

Function
REQ-012 The FSM SHALL have exactly six states: LOW, FILT_UP, SET_P, HIGH, FILT_DN, RST_P.
REQ-013 LOW: on a sample with en=1 and d=1, go to FILT_UP with filter count 1; otherwise stay in LOW.
REQ-014 FILT_UP: on a sample with d=0 or en=0, return to LOW with count cleared; on a sample with d=1, increment the count.
REQ-015 FILT_UP: when the count reaches DEB_CYCLES, go to SET_P; s SHALL be high starting the cycle after the DEB_CYCLES-th consecutive high sample.
REQ-016 DEB_CYCLES=1: the first high sample taken in LOW goes directly to SET_P, so s is high the next cycle.
REQ-017 SET_P: s=1 for exactly PULSE_W cycles, then go to HIGH; level becomes 1 on the same edge s first rises.
REQ-018 HIGH, FILT_DN, RST_P SHALL mirror LOW, FILT_UP, SET_P with d inverted, r in place of s, and level becoming 0.
REQ-019 During SET_P and RST_P, d and en are ignored and the pulse always completes in full.
REQ-020 A level change of d that occurs during a pulse is filtered from its first sample in HIGH (or LOW) after the pulse.
REQ-021 s and r SHALL never be high in the same cycle, and neither SHALL be high outside SET_P or RST_P.
REQ-022 Back-to-back pulses SHALL be separated by at least DEB_CYCLES low cycles on both s and r.
REQ-023 busy=1 in FILT_UP, SET_P, FILT_DN and RST_P; busy=0 in LOW and HIGH.
REQ-024 evt_cnt SHALL increment by 1 on the edge each pulse begins and wrap from 255 to 0.
REQ-025 en=0 in LOW or HIGH: hold state; no new filtering starts.
REQ-026 All outputs SHALL be driven directly from flip-flops, with no combinational path from input to output.

Reset
REQ-027 While rst_n=0, the block SHALL immediately, without waiting for a clock edge, force state LOW, s=0, r=0, level=0, busy=0, evt_cnt=0, and filter count 0.
REQ-028 Reset asserted mid-pulse SHALL truncate the pulse at once and no pulse SHALL resume after release.
REQ-029 After rst_n rises, the first sample SHALL be taken on the next rising clk edge; d=1 at that edge starts FILT_UP.

Verification (DEB_CYCLES=4, PULSE_W=2 unless stated)
REQ-030 Reset, en=1, d held 1 from edge 1 -> s=1 after edges 4 and 5 only, level=1 from edge 4, evt_cnt=1, busy=0 from edge 6.
REQ-031 From HIGH, d low for 3 cycles then high -> no r pulse, return to HIGH, evt_cnt unchanged.
REQ-032 d toggles low during SET_P and stays low -> s pulse completes (2 cycles); r pulse begins 4 samples after entry to HIGH; s and r never overlap.
REQ-033 rst_n pulled low asynchronously in the middle of the first r cycle -> r, level and evt_cnt are 0 before the next clk edge.
REQ-034 256 full set/reset pulses -> evt_cnt wraps to 0; en=0 with d toggling -> no pulses, busy stays 0.
REQ-035 DEB_CYCLES=1, PULSE_W=1, d alternating every 3 cycles -> single-cycle s and r alternately, each one cycle after its edge.
